// File: rtl/scope_display_buffer.sv
// Double-buffered ch1/ch2 display store: copies COPY_LEN trigger-aligned samples into the back bank
// once per copy window and swaps banks at frame start. Optional saturation: SCOPE_DISP_CLAMP_EN.
module scope_display_buffer #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned COPY_LEN  = 500,
  parameter int unsigned CLAMP_MAX = 250
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              memcpy_window,
  input  logic              frame_start,
  input  logic              cap_valid,
  input  logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] cap_rd_addr,
  input  logic [8:0]        cap_ch1_data,
  input  logic [8:0]        cap_ch2_data,
  output logic              cap_ack,
  input  logic [ADDR_W-1:0] displ_mem_rd_addr,
  output logic [8:0]        ch1_disp_sig,
  output logic [8:0]        ch2_disp_sig,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {StIdle, StCopy, StAck} state_e;

  localparam logic [ADDR_W:0]       CopyLen = COPY_LEN[ADDR_W:0];
  localparam logic signed [8:0]     ClampHi = CLAMP_MAX[8:0];
  localparam logic signed [8:0]     ClampLo = -ClampHi;
`ifdef SCOPE_DISP_CLAMP_EN
  localparam bit ClampEn = 1'b1;
`else
  localparam bit ClampEn = 1'b0;
`endif

  state_e            state_q;
  logic [ADDR_W:0]   idx_q;
  logic              front_q;
  logic              swap_pending_q;
  logic              win_q;
  logic              req;
  logic              wr_en;
  logic [ADDR_W:0]   wr_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [8:0]        ch1_w;
  logic [8:0]        ch2_w;

  // Bank select is the MSB of the combined array; back bank is always ~front_q.
  logic [17:0] bank_mem [0:2**(ADDR_W+1)-1];

  function automatic logic [8:0] sat(input logic [8:0] s);
    if (ClampEn && $signed(s) > ClampHi) return ClampHi;
    if (ClampEn && $signed(s) < ClampLo) return ClampLo;
    return s;
  endfunction

  always_comb begin
    req     = memcpy_window & ~win_q;
    wr_en   = (state_q == StCopy) && (idx_q != '0);
    wr_idx  = idx_q - 1'b1;
    wr_addr = wr_idx[ADDR_W-1:0];
    ch1_w   = sat(cap_ch1_data);
    ch2_w   = sat(cap_ch2_data);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      front_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      win_q          <= 1'b0;
      cap_rd_addr    <= '0;
      cap_ack        <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      win_q   <= memcpy_window;
      overrun <= 1'b0;
      cap_ack <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req && cap_valid) begin
            if (swap_pending_q) begin
              overrun <= 1'b1;
            end else begin
              cap_rd_addr <= trig_addr;
              idx_q       <= '0;
              busy        <= 1'b1;
              state_q     <= StCopy;
            end
          end
        end
        StCopy: begin
          // Read address runs one ahead of the write index; data lags by one cycle.
          cap_rd_addr <= cap_rd_addr + 1'b1;
          if (idx_q == CopyLen) begin
            busy    <= 1'b0;
            cap_ack <= 1'b1;
            state_q <= StAck;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StAck: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (frame_start && (swap_pending_q || state_q == StAck)) begin
        front_q        <= ~front_q;
        swap_pending_q <= 1'b0;
      end else if (state_q == StAck) begin
        swap_pending_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (wr_en) bank_mem[{~front_q, wr_addr}] <= {ch2_w, ch1_w};
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      ch1_disp_sig <= '0;
      ch2_disp_sig <= '0;
    end else if ({1'b0, displ_mem_rd_addr} >= CopyLen) begin
      ch1_disp_sig <= '0;
      ch2_disp_sig <= '0;
    end else begin
      {ch2_disp_sig, ch1_disp_sig} <= bank_mem[{front_q, displ_mem_rd_addr}];
    end
  end

endmodule

// File: doc/scope_display_buffer.md
Name: scope_display_buffer

Overview:
- Double-buffered display sample store directly upstream of the 800x600 VGA interface/GPU.
- Once per frame, when the display copy window opens, copies COPY_LEN trigger-aligned ch1/ch2 sample pairs from the capture RAM into the back bank.
- Swaps banks at the next frame start, so the GPU always reads a complete, tear-free frame through its displ_mem_rd_addr port.

Parameters:
- ADDR_W, 9, address width of capture RAM and each display bank (depth 2**ADDR_W).
- COPY_LEN, 500, samples copied per frame; display addresses >= COPY_LEN read as 0.
- CLAMP_MAX, 250, magnitude limit used only with the optional feature.

Ports:
- vga_clk  in  1  single clock, pixel clock domain.
- reset  in  1  asynchronous, active-high reset.
- memcpy_window  in  1  copy window from VGA interface; its rising edge requests a copy.
- frame_start  in  1  one-cycle pulse at row 0, col 0; bank swap point.
- cap_valid  in  1  capture side has a complete triggered record ready (level).
- trig_addr  in  ADDR_W  capture-RAM address of the first displayed sample.
- cap_rd_addr  out  ADDR_W  capture RAM read address; RAM data returns 1 cycle later.
- cap_ch1_data  in  9  signed ch1 sample from capture RAM.
- cap_ch2_data  in  9  signed ch2 sample from capture RAM.
- cap_ack  out  1  one-cycle pulse when a copy completes; capture may re-arm.
- displ_mem_rd_addr  in  ADDR_W  GPU read address.
- ch1_disp_sig  out  9  signed ch1 display sample, registered.
- ch2_disp_sig  out  9  signed ch2 display sample, registered.
- busy  out  1  high while state is COPY.
- overrun  out  1  one-cycle pulse when a copy request is dropped.

Behaviour:
- Reset (async, immediate):
  - State IDLE, front bank 0, swap_pending 0, idx 0.
  - All outputs 0, including cap_rd_addr.
  - Bank RAM contents are not reset.
- Request: the rising edge of memcpy_window is detected with a registered previous value.
- IDLE transitions, evaluated on a request only:
  - cap_valid=1 and swap_pending=0: latch base=trig_addr, go to COPY.
  - cap_valid=0: no action, no overrun pulse.
  - swap_pending=1: no copy; overrun pulses for one cycle.
- COPY:
  - Cycle k (k=0..COPY_LEN-1): cap_rd_addr = (base+k) mod 2**ADDR_W; wrap is natural ADDR_W overflow.
  - Cycle k+1: the returned pair is written to back bank address k.
  - Last write occurs COPY_LEN cycles after entry, then go to ACK.
  - memcpy_window falling during COPY has no effect.
  - COPY lasts COPY_LEN+1 cycles (501 at defaults).
- ACK: cap_ack=1 for exactly one cycle, swap_pending set, return to IDLE.
- Swap:
  - On frame_start with swap_pending=1 (or in the ACK cycle itself): invert front bank, clear swap_pending.
  - A frame_start with nothing pending does nothing.
- Display read:
  - ch*_disp_sig <= front_bank[displ_mem_rd_addr], 1-cycle latency.
  - Outputs 0 when displ_mem_rd_addr >= COPY_LEN.
  - A bank swap affects reads issued in the cycle after the swap.
- Width rules: samples are stored at 9 bits signed, no arithmetic unless the optional feature is enabled.
- Reset mid-COPY: the copy is abandoned and no cap_ack is issued; the front bank reverts to 0 and its contents are undefined until the next complete copy and swap.

Optional Feature:
- SCOPE_DISP_CLAMP_EN defined:
  - Samples are saturated on write: > CLAMP_MAX -> CLAMP_MAX; < -CLAMP_MAX -> -CLAMP_MAX.
  - Comparison is signed, 9-bit.
- Undefined: samples pass through unmodified (-256..255).

Test Plan:
- Basic copy: capture RAM addr i holds ch1=i[8:0], ch2=-i; trig_addr=0, cap_valid=1; pulse memcpy_window -> busy for 501 cycles, cap_ack 1 cycle; after the next frame_start, read addr 37 -> ch1=37, ch2=-37 one cycle later.
- Wrap-around: trig_addr=400 -> cap_rd_addr runs 400..511, 0..387; display addr 111 = capture 511, addr 112 = capture 0.
- Double buffering: frame A shown; start copy B, read addr 5 mid-copy -> still A value; after ack with no frame_start -> still A; after frame_start -> B value.
- Overrun / no data:
  - Second memcpy_window edge before frame_start -> overrun pulse, no busy, no cap_ack.
  - cap_valid=0 at the edge -> nothing happens, overrun stays 0.
- Reset mid-copy: assert reset at COPY cycle 200 -> busy=0, cap_ack never pulses, outputs 0; a fresh copy then completes normally.
- Clamp (macro defined): samples 255 and -256 -> displayed 250 and -250. Macro undefined -> 255 and -256.
